braille_entry: RTL and testbench
================================

# braille_entry

Captures one Braille cell from the trainer's six raw dot switches and a raw "enter" pushbutton, and hands a clean, latched 6-bit pattern to the alphabet decoder stage. Each input is debounced, a cell is captured on the debounced rising edge of enter, and the pattern is held with a valid/ack handshake until the downstream scorer accepts it. An all-zero (empty) cell is rejected with a one-cycle error pulse.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles an input must differ from its debounced value before the debounced value changes; legal range 2..65535.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- dots_in  in  6  raw dot switches; bit i = dot i+1, asynchronous to clk.
- enter_in  in  1  raw enter pushbutton, active-high, asynchronous to clk.
- user_ack  in  1  downstream accepts the held cell; sampled only while user_valid=1.
- user  out  6  latched cell pattern, decoder input format.
- user_valid  out  1  user holds a new, unaccepted cell.
- empty_err  out  1  one-cycle pulse: enter pressed with all dots released.
- busy  out  1  high in any state other than IDLE.

## Operation
- Debounce, per input (7 identical instances): sample s, debounced value db, counter cnt sized for DEBOUNCE_CYCLES-1.
  - s == db: cnt <= 0.
  - s != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != db and cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches db.
- Edge detect: enter_rise = enter_db & ~enter_db_q (enter_db_q registered one cycle).
- FSM states IDLE, HOLD, WAIT_REL:
  - IDLE: enter_rise and dots_db != 0 -> user <= dots_db, user_valid <= 1, go HOLD. enter_rise and dots_db == 0 -> empty_err <= 1 for one cycle, go WAIT_REL. Otherwise stay.
  - HOLD: user and user_valid stable; dots_in changes ignored. user_ack=1 -> user_valid <= 0, go WAIT_REL (user keeps last value).
  - WAIT_REL: enter_db == 0 -> go IDLE. A second press requires a debounced release first; no auto-repeat.
- Reset: user=0, user_valid=0, empty_err=0, busy=0, all db=0, all cnt=0, enter_db_q=0, state IDLE. Reset mid-HOLD drops user_valid on the reset edge; the cell is lost.
- Enter held through reset release: enter_db rises after debounce and is captured as a normal press.
- enter_rise while in HOLD or WAIT_REL: ignored.

## Timing
- Raw edge first sampled at clock edge E, input stable thereafter.
- SYNC_EN defined: db updates at E+1+DEBOUNCE_CYCLES; user_valid/empty_err assert after edge E+2+DEBOUNCE_CYCLES.
- SYNC_EN undefined: db updates at E+DEBOUNCE_CYCLES-1; outputs assert after edge E+DEBOUNCE_CYCLES.
- user_ack high at edge A during HOLD: user_valid low after A; busy stays high until the edge after enter_db is seen low.
- Captured pattern is dots_db at the capture edge. Dots must be stable DEBOUNCE_CYCLES before enter to be included.
- Throughput: at most one cell per press-release pair.

## Configuration
- BRAILLE_ENTRY_SYNC_EN defined: each raw input passes a 2-flop synchronizer before debounce; s = second flop. Adds 2 cycles of latency.
- Undefined: s = raw input directly. Only for benches or inputs already synchronous to clk.

## Test plan
- DEBOUNCE_CYCLES=4, SYNC_EN on: dots_in=6'b000101 stable, enter_in pulsed high 20 cycles -> user=6'b000101, user_valid high exactly 6 cycles after the first sampling edge, held until user_ack.
- Enter glitch of 3 cycles (DEBOUNCE_CYCLES=4) -> no user_valid, no empty_err, busy stays 0.
- dots_in=0, enter pressed -> empty_err one-cycle pulse; user_valid stays 0; busy until enter released and debounced.
- In HOLD, dots_in changed to 6'b111011 with no ack -> user stays 6'b000101. Ack, release, press again -> user=6'b111011.
- Enter held, user_ack after 2 cycles -> user_valid drops. No second capture until enter debounced low then high.
- rst asserted one cycle during HOLD -> all outputs 0 after that edge, state IDLE. SYNC_EN off, DEBOUNCE_CYCLES=4 -> press latency 4 cycles.

Source files
------------

// File: rtl/braille_entry.sv
// Braille cell entry: debounces six dot switches and an enter button, then latches one cell per press.
// Optional BRAILLE_ENTRY_SYNC_EN puts a 2-flop synchronizer in front of every raw input.
module braille_entry #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] dots_in,
   input  logic       enter_in,
   input  logic       user_ack,
   output logic [5:0] user,
   output logic       user_valid,
   output logic       empty_err,
   output logic       busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] HOLD     = 2'd1;
   localparam logic [1:0] WAIT_REL = 2'd2;

   logic [6:0] raw_s;
   logic [6:0] samp_s;
   logic [6:0] db_s;
   logic [5:0] dots_db_s;
   logic       enter_db_s;
   logic       enter_db_q_r;
   logic       enter_rise_s;

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic [5:0] user_r;
   logic [5:0] user_nxt_s;
   logic       valid_r;
   logic       valid_nxt_s;
   logic       err_r;
   logic       err_nxt_s;
   logic       busy_r;

   assign raw_s = {enter_in, dots_in};

`ifdef BRAILLE_ENTRY_SYNC_EN
   logic [6:0] sync1_r;
   logic [6:0] sync2_r;

   // two-flop synchronizer for the asynchronous switch inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 7'b0;
         sync2_r <= 7'b0;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

   assign samp_s = sync2_r;
`else
   assign samp_s = raw_s;
`endif

   for (genvar i = 0; i < 7; i++) begin : g_db
      logic          db_bit_r;
      logic [CW-1:0] cnt_r;

      // debounced value flips only after CNT_MAX+1 consecutive disagreeing samples
      always_ff @(posedge clk) begin
         if (rst) begin
            db_bit_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
         end else if (samp_s[i] == db_bit_r) begin
            cnt_r    <= {CW{1'b0}};
         end else if (cnt_r == CNT_MAX) begin
            db_bit_r <= samp_s[i];
            cnt_r    <= {CW{1'b0}};
         end else begin
            cnt_r    <= cnt_r + CW'(1);
         end
      end

      assign db_s[i] = db_bit_r;
   end

   assign dots_db_s    = db_s[5:0];
   assign enter_db_s   = db_s[6];
   assign enter_rise_s = enter_db_s & ~enter_db_q_r;

   // next-state and output decode for the capture FSM
   always_comb begin
      state_nxt_s = state_r;
      user_nxt_s  = user_r;
      valid_nxt_s = valid_r;
      err_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (enter_rise_s) begin
               if (dots_db_s != 6'b0) begin
                  user_nxt_s  = dots_db_s;
                  valid_nxt_s = 1'b1;
                  state_nxt_s = HOLD;
               end else begin
                  err_nxt_s   = 1'b1;
                  state_nxt_s = WAIT_REL;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         HOLD: begin
            if (user_ack && valid_r) begin
               valid_nxt_s = 1'b0;
               state_nxt_s = WAIT_REL;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         WAIT_REL: begin
            // a new press is only armed after enter is seen released
            if (!enter_db_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT_REL;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // state, outputs and enter edge history
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         user_r       <= 6'b0;
         valid_r      <= 1'b0;
         err_r        <= 1'b0;
         busy_r       <= 1'b0;
         enter_db_q_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         user_r       <= user_nxt_s;
         valid_r      <= valid_nxt_s;
         err_r        <= err_nxt_s;
         busy_r       <= (state_nxt_s != IDLE);
         enter_db_q_r <= enter_db_s;
      end
   end

   assign user       = user_r;
   assign user_valid = valid_r;
   assign empty_err  = err_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_braille_entry.sv
// Directed bench for braille_entry with DEBOUNCE_CYCLES=4; latency adapts to BRAILLE_ENTRY_SYNC_EN.
module tb_braille_entry;

   localparam int D = 4;
`ifdef BRAILLE_ENTRY_SYNC_EN
   localparam int LAT = D + 2;
`else
   localparam int LAT = D;
`endif

   logic       clk;
   logic       rst;
   logic [5:0] dots_in;
   logic       enter_in;
   logic       user_ack;
   logic [5:0] user;
   logic       user_valid;
   logic       empty_err;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   braille_entry #(.DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .dots_in    (dots_in),
      .enter_in   (enter_in),
      .user_ack   (user_ack),
      .user       (user),
      .user_valid (user_valid),
      .empty_err  (empty_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; dots_in = 6'b0; enter_in = 1'b0; user_ack = 1'b0;
      tick(2);
      n_cmp++; if (user !== 6'b0) begin $display("FAIL reset_user got %b want %b", user, 6'b0); n_bad++; end
      n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", user_valid); n_bad++; end
      n_cmp++; if (empty_err !== 1'b0) begin $display("FAIL reset_err got %b want 0", empty_err); n_bad++; end
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_bad++; end
      rst = 1'b0;
      tick(3);
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL post_reset_busy got %b want 0", busy); n_bad++; end
   endtask

   task automatic test_capture;
      dots_in = 6'b000101;
      tick(LAT + 2);
      enter_in = 1'b1;
      tick(LAT);
      n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL cap_early got %b want 0", user_valid); n_bad++; end
      tick(1);
      n_cmp++; if (user_valid !== 1'b1) begin $display("FAIL cap_valid got %b want 1", user_valid); n_bad++; end
      n_cmp++; if (user !== 6'b000101) begin $display("FAIL cap_user got %b want %b", user, 6'b000101); n_bad++; end
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL cap_busy got %b want 1", busy); n_bad++; end
      n_cmp++; if (empty_err !== 1'b0) begin $display("FAIL cap_err got %b want 0", empty_err); n_bad++; end
      dots_in = 6'b111011;
      tick(10);
      n_cmp++; if (user !== 6'b000101) begin $display("FAIL hold_user got %b want %b", user, 6'b000101); n_bad++; end
      n_cmp++; if (user_valid !== 1'b1) begin $display("FAIL hold_valid got %b want 1", user_valid); n_bad++; end
      user_ack = 1'b1;
      tick(1);
      user_ack = 1'b0;
      n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL ack_valid got %b want 0", user_valid); n_bad++; end
      n_cmp++; if (user !== 6'b000101) begin $display("FAIL ack_user got %b want %b", user, 6'b000101); n_bad++; end
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL ack_busy got %b want 1", busy); n_bad++; end
      enter_in = 1'b0;
      tick(LAT);
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL rel_busy_early got %b want 1", busy); n_bad++; end
      tick(1);
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL rel_busy got %b want 0", busy); n_bad++; end
      enter_in = 1'b1;
      tick(LAT + 1);
      n_cmp++; if (user_valid !== 1'b1) begin $display("FAIL cap2_valid got %b want 1", user_valid); n_bad++; end
      n_cmp++; if (user !== 6'b111011) begin $display("FAIL cap2_user got %b want %b", user, 6'b111011); n_bad++; end
      user_ack = 1'b1;
      tick(1);
      user_ack = 1'b0;
      enter_in = 1'b0;
      tick(LAT + 2);
   endtask

   task automatic test_glitch;
      enter_in = 1'b1;
      tick(3);
      enter_in = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL glitch_valid[%0d] got %b want 0", i, user_valid); n_bad++; end
         n_cmp++; if (empty_err !== 1'b0) begin $display("FAIL glitch_err[%0d] got %b want 0", i, empty_err); n_bad++; end
         n_cmp++; if (busy !== 1'b0) begin $display("FAIL glitch_busy[%0d] got %b want 0", i, busy); n_bad++; end
      end
   endtask

   task automatic test_empty;
      dots_in = 6'b0;
      tick(LAT + 2);
      enter_in = 1'b1;
      tick(LAT);
      n_cmp++; if (empty_err !== 1'b0) begin $display("FAIL empty_early got %b want 0", empty_err); n_bad++; end
      tick(1);
      n_cmp++; if (empty_err !== 1'b1) begin $display("FAIL empty_pulse got %b want 1", empty_err); n_bad++; end
      n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL empty_valid got %b want 0", user_valid); n_bad++; end
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL empty_busy got %b want 1", busy); n_bad++; end
      tick(1);
      n_cmp++; if (empty_err !== 1'b0) begin $display("FAIL empty_one_cycle got %b want 0", empty_err); n_bad++; end
      tick(5);
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL empty_held_busy got %b want 1", busy); n_bad++; end
      n_cmp++; if (empty_err !== 1'b0) begin $display("FAIL empty_held_err got %b want 0", empty_err); n_bad++; end
      enter_in = 1'b0;
      tick(LAT);
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL empty_rel_early got %b want 1", busy); n_bad++; end
      tick(1);
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL empty_rel_busy got %b want 0", busy); n_bad++; end
   endtask

   task automatic test_ack_held;
      dots_in = 6'b000101;
      tick(LAT + 2);
      enter_in = 1'b1;
      tick(LAT + 1);
      n_cmp++; if (user_valid !== 1'b1) begin $display("FAIL ah_valid got %b want 1", user_valid); n_bad++; end
      tick(2);
      user_ack = 1'b1;
      tick(1);
      user_ack = 1'b0;
      n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL ah_ack got %b want 0", user_valid); n_bad++; end
      for (int i = 0; i < 12; i++) begin
         tick(1);
         n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL ah_norepeat[%0d] got %b want 0", i, user_valid); n_bad++; end
         n_cmp++; if (busy !== 1'b1) begin $display("FAIL ah_busy[%0d] got %b want 1", i, busy); n_bad++; end
      end
      enter_in = 1'b0;
      tick(LAT + 1);
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL ah_rel_busy got %b want 0", busy); n_bad++; end
      enter_in = 1'b1;
      tick(LAT + 1);
      n_cmp++; if (user_valid !== 1'b1) begin $display("FAIL ah_repress_valid got %b want 1", user_valid); n_bad++; end
      n_cmp++; if (user !== 6'b000101) begin $display("FAIL ah_repress_user got %b want %b", user, 6'b000101); n_bad++; end
      user_ack = 1'b1;
      tick(1);
      user_ack = 1'b0;
      enter_in = 1'b0;
      tick(LAT + 2);
   endtask

   task automatic test_reset_hold;
      dots_in = 6'b111011;
      tick(LAT + 2);
      enter_in = 1'b1;
      tick(LAT + 1);
      n_cmp++; if (user_valid !== 1'b1) begin $display("FAIL rh_valid got %b want 1", user_valid); n_bad++; end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_cmp++; if (user !== 6'b0) begin $display("FAIL rh_user got %b want %b", user, 6'b0); n_bad++; end
      n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL rh_valid0 got %b want 0", user_valid); n_bad++; end
      n_cmp++; if (empty_err !== 1'b0) begin $display("FAIL rh_err got %b want 0", empty_err); n_bad++; end
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL rh_busy got %b want 0", busy); n_bad++; end
      tick(LAT);
      n_cmp++; if (user_valid !== 1'b0) begin $display("FAIL rh_held_early got %b want 0", user_valid); n_bad++; end
      tick(1);
      n_cmp++; if (user_valid !== 1'b1) begin $display("FAIL rh_held_valid got %b want 1", user_valid); n_bad++; end
      n_cmp++; if (user !== 6'b111011) begin $display("FAIL rh_held_user got %b want %b", user, 6'b111011); n_bad++; end
      user_ack = 1'b1;
      tick(1);
      user_ack = 1'b0;
      enter_in = 1'b0;
      tick(LAT + 2);
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL rh_final_busy got %b want 0", busy); n_bad++; end
   endtask

   initial begin
      rst = 1'b1; dots_in = 6'b0; enter_in = 1'b0; user_ack = 1'b0;
      test_reset();
      test_capture();
      test_glitch();
      test_empty();
      test_ack_held();
      test_reset_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
